// File: rtl/program_counter_pkg.sv
// Shared definitions for the instruction-fetch program counter.
package program_counter_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned INCR  = 1;

    typedef logic [WIDTH-1:0] pc_addr_t;

    localparam pc_addr_t RESET_ADDR = '0;

endpackage

// File: rtl/program_counter_pc_adder.sv
// Combinational incrementer: {cout, result} = dataA + INCR + cin in WIDTH+1 bits.
module pc_adder
    import program_counter_pkg::*;
(
    input  logic [WIDTH-1:0] dataA,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    localparam int unsigned SUM_W = WIDTH + 1;

    logic [SUM_W-1:0] sum;

    assign sum           = SUM_W'(dataA) + SUM_W'(INCR) + SUM_W'(cin);
    assign {cout, result} = sum;

endmodule

// File: rtl/program_counter.sv
// IF-stage program counter: register, load mux, enable and optional sticky wrap flag.
// Optional feature: define PC_OVERFLOW_FLAG_EN to build the pc_overflow register.
module program_counter
    import program_counter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enablePC,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_addr,
    output logic [WIDTH-1:0] memAddressOut,
    output logic [WIDTH-1:0] memAddress,
    output logic             cout,
    output logic             pc_overflow
);

    pc_addr_t pcReg;

    pc_adder u_adder (
        .dataA  (pcReg),
        .cin    (1'b0),
        .result (memAddress),
        .cout   (cout)
    );

    // Priority: reset > load > increment > hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcReg <= RESET_ADDR;
        end else if (load_en) begin
            pcReg <= load_addr;
        end else if (enablePC) begin
            pcReg <= memAddress;
        end
    end

    assign memAddressOut = pcReg;

`ifdef PC_OVERFLOW_FLAG_EN
    logic overflowFlag;

    // Sticky until reset; only a real increment that wraps sets it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflowFlag <= 1'b0;
        end else if (!load_en && enablePC && cout) begin
            overflowFlag <= 1'b1;
        end
    end

    assign pc_overflow = overflowFlag;
`else
    assign pc_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: driver pushes model expectations, monitor checks.
module tb_program_counter;

    localparam int unsigned W    = 32;
    localparam int unsigned STEP = 1;

    typedef struct {
        logic [W-1:0] pc;
        logic [W-1:0] nxt;
        logic         c;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enablePC;
    logic         load_en;
    logic [W-1:0] load_addr;
    logic [W-1:0] memAddressOut;
    logic [W-1:0] memAddress;
    logic         cout;
    logic         pc_overflow;

    int checks   = 0;
    int failures = 0;

    exp_t expQ[$];

    logic [W-1:0] mPc    = '0;
    logic         mOvf   = 1'b0;
    logic         mValid = 1'b0;

    program_counter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enablePC      (enablePC),
        .load_en       (load_en),
        .load_addr     (load_addr),
        .memAddressOut (memAddressOut),
        .memAddress    (memAddress),
        .cout          (cout),
        .pc_overflow   (pc_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: next PC from the update rules, plain wide arithmetic for the sum
    task automatic drive(input logic r, input logic e, input logic l, input logic [W-1:0] a);
        longint unsigned s;
        exp_t x;
        @(negedge clk);
        rst_n     = r;
        enablePC  = e;
        load_en   = l;
        load_addr = a;
        if (!r) begin
            mPc    = '0;
            mOvf   = 1'b0;
            mValid = 1'b1;
        end else if (mValid) begin
            if (l) begin
                mPc = a;
            end else if (e) begin
                s = longint'(mPc) + longint'(STEP);
                if (s >= (64'd1 << W)) mOvf = 1'b1;
                mPc = W'(s % (64'd1 << W));
            end
        end
        if (mValid) begin
            s     = longint'(mPc) + longint'(STEP);
            x.pc  = mPc;
            x.nxt = W'(s % (64'd1 << W));
            x.c   = (s >= (64'd1 << W));
`ifdef PC_OVERFLOW_FLAG_EN
            x.ovf = mOvf;
`else
            x.ovf = 1'b0;
`endif
            expQ.push_back(x);
        end
    endtask

    // Monitor: one expectation per edge, sampled just after the edge
    initial begin
        forever begin
            exp_t x;
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                x = expQ.pop_front();
                check("memAddressOut", memAddressOut, x.pc);
                check("memAddress",    memAddress,    x.nxt);
                check("cout",          W'(cout),        W'(x.c));
                check("pc_overflow",   W'(pc_overflow), W'(x.ovf));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        enablePC  = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;

        // Reset for 2 edges, then hold at 0
        drive(0, 1, 1, 32'h1234_5678);
        drive(0, 0, 0, '0);
        repeat (3) drive(1, 0, 0, '0);

        // Five increments, then hold
        repeat (5) drive(1, 1, 0, '0);
        repeat (3) drive(1, 0, 0, '0);

        // Load wins over enable, then one increment
        drive(1, 1, 1, 32'h0000_1000);
        drive(1, 1, 0, '0);

        // Top-of-range wrap, then further increments
        drive(1, 0, 1, 32'hFFFF_FFFF);
        drive(1, 0, 0, '0);
        repeat (3) drive(1, 1, 0, '0);
        drive(1, 0, 1, 32'hFFFF_FFFE);
        repeat (3) drive(1, 1, 0, '0);

        // Reset mid-run with enable high
        drive(1, 0, 1, 32'h0000_1001);
        drive(0, 1, 0, '0);
        drive(1, 0, 0, '0);

        // Enable toggled every 10 cycles from reset
        drive(0, 0, 0, '0);
        for (int ph = 0; ph < 4; ph++) begin
            repeat (10) drive(1, logic'(ph % 2), 0, '0);
        end

        // Randomized traffic with frequent near-wrap loads
        for (int i = 0; i < 2000; i++) begin
            logic [W-1:0] a;
            a = ($urandom_range(3) == 0) ? (32'hFFFF_FFFF - W'($urandom_range(3))) : $urandom;
            drive(logic'($urandom_range(31) != 0), logic'($urandom_range(1)),
                  logic'($urandom_range(7) == 0), a);
        end

        @(posedge clk);
        #3;
        check("queue_drained", W'(expQ.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
